// File: rtl/ooo_pkg.sv
// -----------------------------------------------------------------------------
// ooo_pkg
// Shared definitions for the out-of-order issue/complete path. The
// reservation station and the FU completion unit both use this package.
//
// Contents
//   DEF_TAG_W      default physical register tag width
//   NUM_FU         number of functional-unit ports (ALU0, ALU1, MEM)
//   NUM_WB         number of wakeup/broadcast slots
//   OP_*           RISC-V major opcodes the execution units recognise
//   fu_idx_e       functional-unit index, also the value broadcast on wb_unit_*
//   fu_state_e     per-unit execution state
//   op_wakes()     1 if an opcode writes rd and must broadcast a wakeup
//   arb_rank_unit  broadcast priority order (rank 0 = highest) within a group
// -----------------------------------------------------------------------------
package ooo_pkg;

    localparam int DEF_TAG_W = 6;
    localparam int NUM_FU    = 3;
    localparam int NUM_WB    = 2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_MEM  = 2'd2
    } fu_idx_e;

    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_EXEC = 2'd1,
        FU_WAIT = 2'd2
    } fu_state_e;

    // Stores and unrecognised opcodes occupy a unit but produce no register
    // result, so they never compete for a broadcast slot.
    function automatic logic op_wakes(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD);
    endfunction

    // Unit order inside one priority group: MEM > ALU0 > ALU1.
    function automatic fu_idx_e arb_rank_unit(input int rank);
        case (rank)
            0:       return FU_MEM;
            1:       return FU_ALU0;
            default: return FU_ALU1;
        endcase
    endfunction

endpackage

// File: rtl/fu_latency_slot.sv
// -----------------------------------------------------------------------------
// fu_latency_slot
// Models one functional unit's execution latency. An accepted issue latches
// the destination tag and opcode and loads a down-counter with LAT-1. When the
// counter reaches zero the unit requests a broadcast slot (if the op writes a
// register) or simply returns to IDLE (stores / unknown opcodes). A request
// that is not granted parks the unit in WAIT with its tag frozen until granted.
//
// Parameters
//   TAG_W   physical tag width
//   LAT     execution latency in cycles (>= 1)
//   CNT_W   counter width, must hold LAT-1
//
// Ports
//   clk        clock
//   reset      synchronous, active-high
//   i_issue    accepted issue this cycle (caller already qualified it with o_free)
//   i_rd       destination tag of the issued op
//   i_opcode   opcode of the issued op
//   i_grant    broadcast slot granted to this unit this cycle
//   o_free     unit is IDLE and may accept an issue
//   o_req      unit requests a broadcast slot this cycle
//   o_wait     unit is in WAIT (lost arbitration earlier)
//   o_tag      latched destination tag
// -----------------------------------------------------------------------------
module fu_latency_slot
    import ooo_pkg::*;
#(
    parameter int TAG_W = DEF_TAG_W,
    parameter int LAT   = 1,
    parameter int CNT_W = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_issue,
    input  logic [TAG_W-1:0] i_rd,
    input  logic [6:0]       i_opcode,
    input  logic             i_grant,
    output logic             o_free,
    output logic             o_req,
    output logic             o_wait,
    output logic [TAG_W-1:0] o_tag
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    fu_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic [6:0]       r_opcode;

    logic w_done;
    logic w_wakes;

    assign w_done  = (r_state == FU_EXEC) && (r_cnt == '0);
    assign w_wakes = op_wakes(r_opcode);

    assign o_free = (r_state == FU_IDLE);
    assign o_wait = (r_state == FU_WAIT);
    assign o_req  = (w_done && w_wakes) || (r_state == FU_WAIT);
    assign o_tag  = r_tag;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FU_IDLE;
            r_cnt    <= '0;
            r_tag    <= '0;
            r_opcode <= '0;
        end else begin
            case (r_state)
                FU_IDLE: begin
                    if (i_issue) begin
                        r_state  <= FU_EXEC;
                        r_cnt    <= CNT_LOAD;
                        r_tag    <= i_rd;
                        r_opcode <= i_opcode;
                    end
                end
                FU_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!w_wakes || i_grant) begin
                        r_state <= FU_IDLE;
                    end else begin
                        r_state <= FU_WAIT;
                    end
                end
                FU_WAIT: begin
                    if (i_grant) begin
                        r_state <= FU_IDLE;
                    end
                end
                default: r_state <= FU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fu_completion_unit.sv
// -----------------------------------------------------------------------------
// fu_completion_unit
// Consumer end of the reservation-station issue interface. Three execution
// units (ALU0, ALU1, MEM) each model their latency in a fu_latency_slot; the
// finished results are arbitrated onto two registered wakeup/broadcast slots.
//
// Arbitration: units already in WAIT beat units finishing this cycle; within a
// group MEM > ALU0 > ALU1. Slot 0 gets the first winner, slot 1 the second.
//
// Parameters
//   TAG_W    physical tag width
//   ALU_LAT  ALU0/ALU1 latency (>= 1)
//   MEM_LAT  MEM latency (>= 1)
//   CNT_W    latency counter width, holds max(ALU_LAT, MEM_LAT)-1
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   issue_valid_1/2/3             issue strobe for ALU0 / ALU1 / MEM
//   rd_i_1/2/3, opcode_i_1/2/3    destination tag and opcode per unit
//   func_units_free[2:0]          bit0 ALU0, bit1 ALU1, bit2 MEM; 1 = idle
//   wb_valid[1:0]                 one-cycle broadcast pulse per slot
//   wb_tag_0/1, wb_unit_0/1       broadcast tag and producing unit per slot
//   err_issue_busy                sticky flag: issue arrived on a busy unit
//
// Optional feature (macro FCU_STATS_EN):
//   stat_bcast_cnt[31:0]          total wakeups broadcast
//   stat_stall_cnt[31:0]          cycles in which any unit sat in WAIT
// -----------------------------------------------------------------------------
module fu_completion_unit
    import ooo_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int ALU_LAT = 1,
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid_1,
    input  logic             issue_valid_2,
    input  logic             issue_valid_3,
    input  logic [TAG_W-1:0] rd_i_1,
    input  logic [TAG_W-1:0] rd_i_2,
    input  logic [TAG_W-1:0] rd_i_3,
    input  logic [6:0]       opcode_i_1,
    input  logic [6:0]       opcode_i_2,
    input  logic [6:0]       opcode_i_3,
    output logic [2:0]       func_units_free,
    output logic [1:0]       wb_valid,
    output logic [TAG_W-1:0] wb_tag_0,
    output logic [TAG_W-1:0] wb_tag_1,
    output logic [1:0]       wb_unit_0,
    output logic [1:0]       wb_unit_1,
    output logic             err_issue_busy
`ifdef FCU_STATS_EN
    ,
    output logic [31:0]      stat_bcast_cnt,
    output logic [31:0]      stat_stall_cnt
`endif
);

    // Per-unit views, indexed by fu_idx_e.
    logic [NUM_FU-1:0] w_issue_v;
    logic [NUM_FU-1:0] w_accept;
    logic [NUM_FU-1:0] w_free;
    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_wait;
    logic [NUM_FU-1:0] w_grant;
    logic [TAG_W-1:0]  w_rd     [NUM_FU];
    logic [6:0]        w_opcode [NUM_FU];
    logic [TAG_W-1:0]  w_tag    [NUM_FU];

    // Arbiter result per broadcast slot.
    logic [NUM_WB-1:0] w_slot_v;
    fu_idx_e           w_slot_unit [NUM_WB];
    logic [TAG_W-1:0]  w_slot_tag  [NUM_WB];

    // Output registers.
    logic [1:0]       r_wb_valid;
    logic [TAG_W-1:0] r_wb_tag_0;
    logic [TAG_W-1:0] r_wb_tag_1;
    logic [1:0]       r_wb_unit_0;
    logic [1:0]       r_wb_unit_1;
    logic             r_err_issue_busy;

    assign w_issue_v = {issue_valid_3, issue_valid_2, issue_valid_1};

    assign w_rd[FU_ALU0]     = rd_i_1;
    assign w_rd[FU_ALU1]     = rd_i_2;
    assign w_rd[FU_MEM]      = rd_i_3;
    assign w_opcode[FU_ALU0] = opcode_i_1;
    assign w_opcode[FU_ALU1] = opcode_i_2;
    assign w_opcode[FU_MEM]  = opcode_i_3;

    // Only an idle unit takes an issue. A unit broadcasting at this edge still
    // shows free=0 during the cycle, so a same-cycle issue to it is dropped.
    assign w_accept = w_issue_v & w_free;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unit
        localparam int UNIT_LAT = (g == int'(FU_MEM)) ? MEM_LAT : ALU_LAT;

        fu_latency_slot #(
            .TAG_W (TAG_W),
            .LAT   (UNIT_LAT),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .i_issue  (w_accept[g]),
            .i_rd     (w_rd[g]),
            .i_opcode (w_opcode[g]),
            .i_grant  (w_grant[g]),
            .o_free   (w_free[g]),
            .o_req    (w_req[g]),
            .o_wait   (w_wait[g]),
            .o_tag    (w_tag[g])
        );
    end

    // Walk the six (group, unit) priority positions in order; the first two
    // requesters found fill slot 0 then slot 1. Positions 0..2 are the WAIT
    // group, 3..5 the units finishing this cycle.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_grant        = '0;
        w_slot_v       = '0;
        w_slot_unit[0] = FU_ALU0;
        w_slot_unit[1] = FU_ALU0;
        w_slot_tag[0]  = '0;
        w_slot_tag[1]  = '0;
        for (int p = 0; p < 2 * NUM_FU; p++) begin
            if (w_req[arb_rank_unit(p % NUM_FU)] &&
                (w_wait[arb_rank_unit(p % NUM_FU)] == (p < NUM_FU))) begin
                if (!w_slot_v[0]) begin
                    w_slot_v[0]    = 1'b1;
                    w_slot_unit[0] = arb_rank_unit(p % NUM_FU);
                    w_slot_tag[0]  = w_tag[arb_rank_unit(p % NUM_FU)];
                    w_grant[arb_rank_unit(p % NUM_FU)] = 1'b1;
                end else if (!w_slot_v[1]) begin
                    w_slot_v[1]    = 1'b1;
                    w_slot_unit[1] = arb_rank_unit(p % NUM_FU);
                    w_slot_tag[1]  = w_tag[arb_rank_unit(p % NUM_FU)];
                    w_grant[arb_rank_unit(p % NUM_FU)] = 1'b1;
                end
            end
        end
    end

    // Broadcast registers: valid is a one-cycle pulse, tag/unit hold their
    // last value when a slot is not granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid       <= '0;
            r_wb_tag_0       <= '0;
            r_wb_tag_1       <= '0;
            r_wb_unit_0      <= '0;
            r_wb_unit_1      <= '0;
            r_err_issue_busy <= 1'b0;
        end else begin
            r_wb_valid <= w_slot_v;
            if (w_slot_v[0]) begin
                r_wb_tag_0  <= w_slot_tag[0];
                r_wb_unit_0 <= w_slot_unit[0];
            end
            if (w_slot_v[1]) begin
                r_wb_tag_1  <= w_slot_tag[1];
                r_wb_unit_1 <= w_slot_unit[1];
            end
            if (|(w_issue_v & ~w_free)) begin
                r_err_issue_busy <= 1'b1;
            end
        end
    end

    assign func_units_free = w_free;
    assign wb_valid        = r_wb_valid;
    assign wb_tag_0        = r_wb_tag_0;
    assign wb_tag_1        = r_wb_tag_1;
    assign wb_unit_0       = r_wb_unit_0;
    assign wb_unit_1       = r_wb_unit_1;
    assign err_issue_busy  = r_err_issue_busy;

`ifdef FCU_STATS_EN
    logic [31:0] r_stat_bcast_cnt;
    logic [31:0] r_stat_stall_cnt;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_bcast_cnt <= '0;
            r_stat_stall_cnt <= '0;
        end else begin
            r_stat_bcast_cnt <= r_stat_bcast_cnt + 32'(w_slot_v[0]) + 32'(w_slot_v[1]);
            if (|w_wait) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
        end
    end

    assign stat_bcast_cnt = r_stat_bcast_cnt;
    assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_fu_completion_unit.sv
// -----------------------------------------------------------------------------
// tb_fu_completion_unit
// Self-checking bench for fu_completion_unit (default build, ALU_LAT=1,
// MEM_LAT=3). A timestamp-based reference model predicts every output after
// every clock edge: each in-flight op is ready at issue_edge + latency,
// broadcast candidates are ranked (already late first, then MEM > ALU0 > ALU1)
// and the two best win. Directed table vectors, hand-written corner
// sequences and a random phase all run against that model.
// -----------------------------------------------------------------------------
module tb_fu_completion_unit;
    import ooo_pkg::*;

    localparam int TW      = 6;
    localparam int ALU_LAT = 1;
    localparam int MEM_LAT = 3;

    logic          clk;
    logic          reset;
    logic          issue_valid_1, issue_valid_2, issue_valid_3;
    logic [TW-1:0] rd_i_1, rd_i_2, rd_i_3;
    logic [6:0]    opcode_i_1, opcode_i_2, opcode_i_3;
    logic [2:0]    func_units_free;
    logic [1:0]    wb_valid;
    logic [TW-1:0] wb_tag_0, wb_tag_1;
    logic [1:0]    wb_unit_0, wb_unit_1;
    logic          err_issue_busy;

    fu_completion_unit #(
        .TAG_W   (TW),
        .ALU_LAT (ALU_LAT),
        .MEM_LAT (MEM_LAT),
        .CNT_W   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid_1   (issue_valid_1),
        .issue_valid_2   (issue_valid_2),
        .issue_valid_3   (issue_valid_3),
        .rd_i_1          (rd_i_1),
        .rd_i_2          (rd_i_2),
        .rd_i_3          (rd_i_3),
        .opcode_i_1      (opcode_i_1),
        .opcode_i_2      (opcode_i_2),
        .opcode_i_3      (opcode_i_3),
        .func_units_free (func_units_free),
        .wb_valid        (wb_valid),
        .wb_tag_0        (wb_tag_0),
        .wb_tag_1        (wb_tag_1),
        .wb_unit_0       (wb_unit_0),
        .wb_unit_1       (wb_unit_1),
        .err_issue_busy  (err_issue_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            cyc;
    bit            m_busy  [3];
    int            m_ready [3];
    logic [TW-1:0] m_tag   [3];
    bit            m_wk    [3];
    logic [1:0]    x_wb;
    logic [TW-1:0] x_tag0, x_tag1;
    logic [1:0]    x_unit0, x_unit1;
    logic          x_err;

    function automatic int rank_of(input int u);
        return (u == 2) ? 0 : ((u == 0) ? 1 : 2);
    endfunction

    function automatic logic [2:0] x_free();
        return {!m_busy[2], !m_busy[1], !m_busy[0]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) m_busy[u] = 0;
        x_wb = '0; x_tag0 = '0; x_tag1 = '0; x_unit0 = '0; x_unit1 = '0; x_err = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] v,
                              input logic [TW-1:0] r0, r1, r2,
                              input logic [6:0] o0, o1, o2);
        bit            fb  [3];
        int            key [3];
        logic [TW-1:0] rr  [3];
        logic [6:0]    oo  [3];
        int            best;
        rr[0] = r0; rr[1] = r1; rr[2] = r2;
        oo[0] = o0; oo[1] = o1; oo[2] = o2;
        cyc++;
        for (int u = 0; u < 3; u++) fb[u] = !m_busy[u];
        x_wb = '0;
        for (int u = 0; u < 3; u++) begin
            key[u] = -1;
            if (m_busy[u] && m_ready[u] <= cyc) begin
                if (!m_wk[u]) m_busy[u] = 0;
                else key[u] = ((m_ready[u] < cyc) ? 0 : 3) + rank_of(u);
            end
        end
        for (int s = 0; s < 2; s++) begin
            best = -1;
            for (int u = 0; u < 3; u++)
                if (key[u] >= 0 && (best < 0 || key[u] < key[best])) best = u;
            if (best >= 0) begin
                m_busy[best] = 0;
                key[best] = -1;
                if (s == 0) begin x_wb[0] = 1'b1; x_tag0 = m_tag[best]; x_unit0 = 2'(best); end
                else        begin x_wb[1] = 1'b1; x_tag1 = m_tag[best]; x_unit1 = 2'(best); end
            end
        end
        for (int u = 0; u < 3; u++) begin
            if (v[u]) begin
                if (fb[u]) begin
                    m_busy[u]  = 1;
                    m_ready[u] = cyc + ((u == 2) ? MEM_LAT : ALU_LAT);
                    m_tag[u]   = rr[u];
                    m_wk[u]    = (oo[u] == OP_R) || (oo[u] == OP_I) || (oo[u] == OP_LOAD);
                end else begin
                    x_err = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("free",   func_units_free, x_free());
        check("wb_valid", wb_valid, x_wb);
        check("wb_tag_0", wb_tag_0, x_tag0);
        check("wb_tag_1", wb_tag_1, x_tag1);
        check("wb_unit_0", wb_unit_0, x_unit0);
        check("wb_unit_1", wb_unit_1, x_unit1);
        check("err_issue_busy", err_issue_busy, x_err);
    endtask

    // One clock: drive inputs (we are 1 time unit past a rising edge), step
    // the model, cross the edge and compare.
    task automatic cycle(input logic [2:0] v,
                         input logic [TW-1:0] r0, r1, r2,
                         input logic [6:0] o0, o1, o2);
        issue_valid_1 = v[0]; issue_valid_2 = v[1]; issue_valid_3 = v[2];
        rd_i_1 = r0; rd_i_2 = r1; rd_i_3 = r2;
        opcode_i_1 = o0; opcode_i_2 = o1; opcode_i_3 = o2;
        model_edge(v, r0, r1, r2, o0, o1, o2);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(3'b000, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        issue_valid_1 = 0; issue_valid_2 = 0; issue_valid_3 = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_free", func_units_free, 3'b111);
        check("rst_wb_valid", wb_valid, 2'b00);
        check("rst_tags", {wb_tag_1, wb_tag_0}, '0);
        check("rst_units", {wb_unit_1, wb_unit_0}, 4'b0000);
        check("rst_err", err_issue_busy, 1'b0);
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]    v;
        logic [TW-1:0] rd0, rd1, rd2;
        logic [6:0]    op0, op1, op2;
        logic [2:0]    e_free;
        logic [1:0]    e_wb;
        logic [TW-1:0] e_tag0;
        logic [1:0]    e_unit0;
        logic          e_err;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [TW-1:0] rd0, rd1, rd2,
                                input logic [6:0] op0, op1, op2,
                                input logic [2:0] e_free, input logic [1:0] e_wb,
                                input logic [TW-1:0] e_tag0, input logic [1:0] e_unit0,
                                input logic e_err);
        vec_t t;
        t.v = v; t.rd0 = rd0; t.rd1 = rd1; t.rd2 = rd2;
        t.op0 = op0; t.op1 = op1; t.op2 = op2;
        t.e_free = e_free; t.e_wb = e_wb; t.e_tag0 = e_tag0; t.e_unit0 = e_unit0; t.e_err = e_err;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]    rv;
        logic [TW-1:0] rr [3];
        logic [6:0]    ro [3];

        reset = 1'b1;
        issue_valid_1 = 0; issue_valid_2 = 0; issue_valid_3 = 0;
        rd_i_1 = '0; rd_i_2 = '0; rd_i_3 = '0;
        opcode_i_1 = '0; opcode_i_2 = '0; opcode_i_3 = '0;
        cyc = 0;
        model_reset();

        // ALU0 wakeup, MEM load, MEM store, ALU1 I-type alongside MEM invalid op
        tbl[0]  = mk(3'b001, 5, 0, 0,  OP_R, 0, 0,          3'b110, 2'b00, 0, 0, 0);
        tbl[1]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b111, 2'b01, 5, 0, 0);
        tbl[2]  = mk(3'b100, 0, 0, 9,  0, 0, OP_LOAD,       3'b011, 2'b00, 5, 0, 0);
        tbl[3]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b011, 2'b00, 5, 0, 0);
        tbl[4]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b011, 2'b00, 5, 0, 0);
        tbl[5]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b111, 2'b01, 9, 2, 0);
        tbl[6]  = mk(3'b100, 0, 0, 12, 0, 0, OP_STORE,      3'b011, 2'b00, 9, 2, 0);
        tbl[7]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b011, 2'b00, 9, 2, 0);
        tbl[8]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b011, 2'b00, 9, 2, 0);
        tbl[9]  = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b111, 2'b00, 9, 2, 0);
        tbl[10] = mk(3'b110, 0, 7, 20, 0, OP_I, 7'h7f,      3'b001, 2'b00, 9, 2, 0);
        tbl[11] = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b011, 2'b01, 7, 1, 0);
        tbl[12] = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b011, 2'b00, 7, 1, 0);
        tbl[13] = mk(3'b000, 0, 0, 0,  0, 0, 0,             3'b111, 2'b00, 7, 1, 0);

        do_reset();

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v, tbl[i].rd0, tbl[i].rd1, tbl[i].rd2,
                  tbl[i].op0, tbl[i].op1, tbl[i].op2);
            check($sformatf("tbl%0d_free", i), func_units_free, tbl[i].e_free);
            check($sformatf("tbl%0d_wb", i), wb_valid, tbl[i].e_wb);
            check($sformatf("tbl%0d_tag0", i), wb_tag_0, tbl[i].e_tag0);
            check($sformatf("tbl%0d_unit0", i), wb_unit_0, tbl[i].e_unit0);
            check($sformatf("tbl%0d_err", i), err_issue_busy, tbl[i].e_err);
        end

        // Three units finish at the same edge: MEM and ALU0 win, ALU1 waits.
        do_reset();
        cycle(3'b100, 0, 0, 3, 0, 0, OP_LOAD);
        idle();
        cycle(3'b011, 1, 2, 0, OP_R, OP_R, 0);
        idle();
        check("align_wb", wb_valid, 2'b11);
        check("align_tags", {wb_tag_1, wb_tag_0}, {6'd1, 6'd3});
        check("align_units", {wb_unit_1, wb_unit_0}, {2'd0, 2'd2});
        check("align_free", func_units_free, 3'b101);
        idle();
        check("wait_wb", wb_valid, 2'b01);
        check("wait_tag0", wb_tag_0, 6'd2);
        check("wait_unit0", wb_unit_0, 2'd1);
        check("wait_free", func_units_free, 3'b111);

        // Back-to-back issue to ALU0: second is dropped and flagged.
        cycle(3'b001, 8, 0, 0, OP_R, 0, 0);
        cycle(3'b001, 9, 0, 0, OP_R, 0, 0);
        check("b2b_wb", wb_valid, 2'b01);
        check("b2b_tag0", wb_tag_0, 6'd8);
        check("b2b_err", err_issue_busy, 1'b1);
        idle();
        check("b2b_no_second", wb_valid, 2'b00);
        check("b2b_err_sticky", err_issue_busy, 1'b1);

        // Reset while MEM executes: result discarded, error cleared.
        cycle(3'b100, 0, 0, 30, 0, 0, OP_LOAD);
        idle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            check("rstmid_no_wb", wb_valid, 2'b00);
            check("rstmid_free", func_units_free, 3'b111);
        end

        // Random traffic against the model, with periodic resets.
        for (int n = 0; n < 450; n++) begin
            if (n % 150 == 149) begin
                do_reset();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    rv[k] = ($urandom_range(0, 9) < 4);
                    rr[k] = TW'($urandom);
                    case ($urandom_range(0, 5))
                        0:       ro[k] = OP_R;
                        1:       ro[k] = OP_I;
                        2:       ro[k] = OP_LOAD;
                        3:       ro[k] = OP_STORE;
                        4:       ro[k] = OP_R;
                        default: ro[k] = 7'($urandom);
                    endcase
                end
                cycle(rv, rr[0], rr[1], rr[2], ro[0], ro[1], ro[2]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
